// File: rtl/scan_seq.sv
// Channel sequencer for a 3-to-8 decoder: walks the unmasked channels in
// ascending order with an enable-low blanking gap around each dwell window.
module scan_seq #(
  parameter int DWELL_W = 16,
  parameter int BLANK   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [2:0]         sel_r, sel_nxt_s;
  logic [3:0]         bcnt_r, bcnt_nxt_s;
  logic [DWELL_W-1:0] dcnt_r, dcnt_nxt_s;
  logic               en_r, busy_r, wrap_r, done_r;
  logic               wrap_nxt_s, done_nxt_s;
  logic [3:0]         above_s;
  logic [2:0]         lowest_s;
  logic               any_s, adv_s, last_blank_s, last_dwell_s;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Returns {found, index} of the nearest set bit strictly above cur.
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Channel search and counter terminal conditions
  always_comb begin
    any_s        = (mask != 8'd0);
    lowest_s     = lowest_set(mask);
    above_s      = next_above(mask, sel_r);
    adv_s        = (state_r == ST_BLANK) && (bcnt_r == 4'd0);
    last_blank_s = (state_r == ST_BLANK) && (bcnt_r == 4'(BLANK - 1));
    last_dwell_s = (dcnt_r <= DWELL_W'(1));
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop && any_s) state_nxt_s = ST_BLANK;
        else                         state_nxt_s = ST_IDLE;
      end
      ST_BLANK: begin
        if (stop)                                  state_nxt_s = ST_IDLE;
        else if (adv_s && !any_s)                  state_nxt_s = ST_IDLE;
        else if (adv_s && !above_s[3] && oneshot)  state_nxt_s = ST_IDLE;
        else if (last_blank_s)                     state_nxt_s = ST_DWELL;
        else                                       state_nxt_s = ST_BLANK;
      end
      ST_DWELL: begin
        if (stop)              state_nxt_s = ST_IDLE;
        else if (last_dwell_s) state_nxt_s = ST_BLANK;
        else                   state_nxt_s = ST_DWELL;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of select, counters and event pulses
  always_comb begin
    sel_nxt_s  = sel_r;
    bcnt_nxt_s = bcnt_r;
    dcnt_nxt_s = dcnt_r;
    wrap_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sel_nxt_s  = lowest_s;
        bcnt_nxt_s = 4'd1;
        dcnt_nxt_s = '0;
      end
      ST_BLANK: begin
        bcnt_nxt_s = bcnt_r + 4'd1;
        if (last_blank_s) dcnt_nxt_s = (dwell == '0) ? DWELL_W'(1) : dwell;
        else              dcnt_nxt_s = dcnt_r;
        // sel moves only here, one full cycle after en dropped
        if (adv_s) begin
          if (above_s[3]) begin
            sel_nxt_s = above_s[2:0];
          end else begin
            sel_nxt_s  = lowest_s;
            wrap_nxt_s = any_s && !oneshot && !stop;
            done_nxt_s = any_s && oneshot && !stop;
          end
        end else begin
          sel_nxt_s = sel_r;
        end
      end
      ST_DWELL: begin
        bcnt_nxt_s = 4'd0;
        dcnt_nxt_s = dcnt_r - DWELL_W'(1);
      end
      default: begin
        sel_nxt_s  = 3'd0;
        bcnt_nxt_s = 4'd0;
        dcnt_nxt_s = '0;
      end
    endcase
    sel_nxt_s  = (state_nxt_s == ST_IDLE) ? 3'd0 : sel_nxt_s;
    bcnt_nxt_s = (state_nxt_s == ST_IDLE) ? 4'd0 : bcnt_nxt_s;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r  <= 3'd0;
      bcnt_r <= 4'd0;
      dcnt_r <= '0;
      en_r   <= 1'b0;
      busy_r <= 1'b0;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      sel_r  <= sel_nxt_s;
      bcnt_r <= bcnt_nxt_s;
      dcnt_r <= dcnt_nxt_s;
      en_r   <= (state_nxt_s == ST_DWELL);
      busy_r <= (state_nxt_s != ST_IDLE);
      wrap_r <= wrap_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign sel  = sel_r;
  assign en   = en_r;
  assign busy = busy_r;
  assign wrap = wrap_r;
  assign done = done_r;

endmodule

// File: tb/tb_scan_seq.sv
// Self-checking bench for scan_seq: per-cycle comparison against a
// time-in-channel reference model, plus directed scenario checks.
module tb_scan_seq;
  localparam int DW = 16;
  localparam int BL = 2;

  logic          clk = 1'b0;
  logic          rst, start, stop, oneshot;
  logic [7:0]    mask;
  logic [DW-1:0] dwell;
  logic [2:0]    sel;
  logic          en, busy, wrap, done;

  int checks = 0;
  int passes = 0;
  int glitch_cnt = 0;

  // Reference model: channel index plus cycles elapsed since that channel's blank started
  logic m_busy, m_wrap, m_done;
  int   m_ch, m_t, m_len;

  scan_seq #(.DWELL_W(DW), .BLANK(BL)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot),
    .mask(mask), .dwell(dwell), .sel(sel), .en(en), .busy(busy),
    .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  // sel must never move while en is high (aborts that drop busy excepted)
  logic [2:0] g_sel = 3'd0;
  logic       g_en  = 1'b0;
  always @(posedge clk) begin
    #1;
    if (g_en && busy && (sel !== g_sel)) glitch_cnt++;
    g_sel = sel;
    g_en  = en;
  end

  function automatic int lowest_m(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [2:0] s;
    s = m_busy ? 3'(m_ch) : 3'd0;
    return {s, (m_busy && (m_t >= BL)), m_busy, m_wrap, m_done};
  endfunction

  task automatic model_step();
    int nxt;
    m_wrap = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_ch = 0; m_t = 0;
    end else if (!m_busy) begin
      if (start && !stop && (mask != 8'h00)) begin
        m_busy = 1'b1; m_ch = lowest_m(mask); m_t = 1;
      end
    end else if (stop) begin
      m_busy = 1'b0;
    end else if (m_t == 0) begin
      nxt = -1;
      for (int i = 7; i > m_ch; i--) if (mask[i]) nxt = i;
      if (mask == 8'h00)  m_busy = 1'b0;
      else if (nxt >= 0)  m_ch = nxt;
      else if (oneshot) begin m_busy = 1'b0; m_done = 1'b1; end
      else begin m_ch = lowest_m(mask); m_wrap = 1'b1; end
      m_t = 1;
    end else if (m_t == BL - 1) begin
      m_len = (dwell == '0) ? 1 : int'(dwell);
      m_t = BL;
    end else if (m_t == BL + m_len - 1) begin
      m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    if ({sel, en, busy, wrap, done} !== 7'b0) begin
      $display("FAIL reset_state got=%b exp=%b", {sel, en, busy, wrap, done}, 7'b0);
    end else passes++;
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    int w0, w1, en_cnt;
    w0 = -1; w1 = -1; en_cnt = 0;
    mask = 8'hFF; dwell = 16'd3; oneshot = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if ({sel, en, busy, wrap, done} !== exp_vec()) begin
        $display("FAIL cont cyc=%0d got=%b exp=%b", c, {sel, en, busy, wrap, done}, exp_vec());
      end else passes++;
      checks++;
      if (w0 >= 0 && w1 < 0 && en) en_cnt++;
      if (wrap) begin
        if (w0 < 0) w0 = c;
        else if (w1 < 0) w1 = c;
      end
    end
    if (w0 != 40 || w1 != 80) begin
      $display("FAIL cont_wrap_period got=%0d,%0d exp=40,80", w0, w1);
    end else passes++;
    checks++;
    if (en_cnt != 24) begin
      $display("FAIL cont_en_per_frame got=%0d exp=24", en_cnt);
    end else passes++;
    checks++;
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_oneshot_masked();
    int seq[$];
    int done_cnt;
    done_cnt = 0;
    mask = 8'b1010_0100; dwell = 16'd1; oneshot = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if ({sel, en, busy, wrap, done} !== exp_vec()) begin
        $display("FAIL oneshot cyc=%0d got=%b exp=%b", c, {sel, en, busy, wrap, done}, exp_vec());
      end else passes++;
      checks++;
      if (en) seq.push_back(int'(sel));
      if (done) done_cnt++;
    end
    if (seq.size() != 3 || seq[0] != 2 || seq[1] != 5 || seq[2] != 7) begin
      $display("FAIL oneshot_seq got_len=%0d exp=2,5,7", seq.size());
    end else passes++;
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      $display("FAIL oneshot_done got=%0d busy=%b exp=1 busy=0", done_cnt, busy);
    end else passes++;
    checks++;
  endtask

  task automatic test_dwell_zero();
    int en_cnt, wr_cnt;
    en_cnt = 0; wr_cnt = 0;
    mask = 8'h01; dwell = 16'd0; oneshot = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    for (int c = 0; c < 30; c++) begin
      step();
      if ({sel, en, busy, wrap, done} !== exp_vec()) begin
        $display("FAIL dwell0 cyc=%0d got=%b exp=%b", c, {sel, en, busy, wrap, done}, exp_vec());
      end else passes++;
      checks++;
      if (en) en_cnt++;
      if (wrap) wr_cnt++;
    end
    if (en_cnt != 10 || wr_cnt != 10) begin
      $display("FAIL dwell0_rate got=en%0d/wrap%0d exp=en10/wrap10", en_cnt, wr_cnt);
    end else passes++;
    checks++;
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_stop();
    bit found;
    found = 1'b0;
    mask = 8'hFF; dwell = 16'd3; oneshot = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if ({sel, en, busy, wrap, done} !== exp_vec()) begin
        $display("FAIL stop_run cyc=%0d got=%b exp=%b", c, {sel, en, busy, wrap, done}, exp_vec());
      end else passes++;
      checks++;
      if (sel == 3'd4 && en) begin found = 1'b1; break; end
    end
    if (!found) begin
      $display("FAIL stop_reach_ch4 got=timeout exp=sel4_en1");
      checks++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    if ({sel, en, busy, wrap, done} !== 7'b0) begin
      $display("FAIL stop_abort got=%b exp=%b", {sel, en, busy, wrap, done}, 7'b0);
    end else passes++;
    checks++;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    if ({sel, en, busy} !== 5'b000_0_1) begin
      $display("FAIL stop_restart got=%b exp=%b", {sel, en, busy}, 5'b000_0_1);
    end else passes++;
    checks++;
    for (int c = 0; c < 12; c++) begin
      step();
      if ({sel, en, busy, wrap, done} !== exp_vec()) begin
        $display("FAIL stop_rescan cyc=%0d got=%b exp=%b", c, {sel, en, busy, wrap, done}, exp_vec());
      end else passes++;
      checks++;
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    mask = 8'hFF; dwell = 16'd3; oneshot = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c > 4 && busy && !en && sel != 3'd0) begin found = 1'b1; break; end
    end
    if (!found) begin
      $display("FAIL arst_reach_blank got=timeout exp=blank");
      checks++;
    end
    #2;
    rst = 1'b1;
    #1;
    if ({sel, en, busy, wrap, done} !== 7'b0) begin
      $display("FAIL arst_immediate got=%b exp=%b", {sel, en, busy, wrap, done}, 7'b0);
    end else passes++;
    checks++;
    step();
    rst = 1'b0;
    step();
    if ({sel, en, busy, wrap, done} !== exp_vec()) begin
      $display("FAIL arst_after got=%b exp=%b", {sel, en, busy, wrap, done}, exp_vec());
    end else passes++;
    checks++;
  endtask

  task automatic test_corners();
    mask = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    step();
    if (busy !== 1'b0) begin
      $display("FAIL start_mask0 got=%b exp=0", busy);
    end else passes++;
    checks++;
    mask = 8'h3C; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    if (busy !== 1'b0) begin
      $display("FAIL start_with_stop got=%b exp=0", busy);
    end else passes++;
    checks++;
    mask = 8'hFF; dwell = 16'd2; oneshot = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (c == 8) mask = 8'h00;
      step();
      if ({sel, en, busy, wrap, done} !== exp_vec()) begin
        $display("FAIL mask_clear cyc=%0d got=%b exp=%b", c, {sel, en, busy, wrap, done}, exp_vec());
      end else passes++;
      checks++;
    end
    if (busy !== 1'b0) begin
      $display("FAIL mask_clear_idle got=%b exp=0", busy);
    end else passes++;
    checks++;
  endtask

  task automatic test_random();
    mask = 8'hFF;
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 39) == 0)
        mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 49) == 0) oneshot = 1'($urandom);
      dwell = 16'($urandom_range(0, 4));
      step();
      if ({sel, en, busy, wrap, done} !== exp_vec()) begin
        $display("FAIL random cyc=%0d mask=%h got=%b exp=%b", c, mask, {sel, en, busy, wrap, done}, exp_vec());
      end else passes++;
      checks++;
    end
    start = 1'b0; stop = 1'b0;
    if (glitch_cnt !== 0) begin
      $display("FAIL sel_glitch got=%0d exp=0", glitch_cnt);
    end else passes++;
    checks++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    mask = 8'h00; dwell = '0;
    m_busy = 1'b0; m_wrap = 1'b0; m_done = 1'b0;
    m_ch = 0; m_t = 0; m_len = 1;
    test_reset();
    test_continuous();
    test_oneshot_masked();
    test_dwell_zero();
    test_stop();
    test_async_reset();
    test_corners();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
